spi_reg_sequencer: RTL

SPI_REG_SEQUENCER -- requirements
Module: spi_reg_sequencer

---
 rtl/spi_reg_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_sequencer.sv
// Register-access sequencer: turns one host read/write command into the
// fixed control/data write and read sequence an SPI master needs for one peripheral register access.
module spi_reg_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    output logic        write_n,
    output logic        read_n,
    input  logic [15:0] data_to_cpu,
    input  logic        readyfordata,
    input  logic        dataavailable
);

    typedef enum logic [3:0] {
        IDLE, SS_ON, WAIT_T1, TX_CMD, WAIT_R1, RD_DUMMY,
        WAIT_T2, TX_DATA, WAIT_R2, RD_DATA, SS_OFF, DONE
    } state_t;

    state_t      state, next_state;
    logic [15:0] cnt;
    logic        write_q;
    logic [4:0]  reg_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rx_byte;
    logic        err_q;
    logic [7:0]  cmd_byte;
    logic        access_state;
    logic        wait_state;
    logic        access_done;
    logic        wait_expired;
    logic        unused_hi;

    assign cmd_byte     = {reg_q, 1'b0, write_q, 1'b0};
    assign access_state = state inside {SS_ON, TX_CMD, RD_DUMMY, TX_DATA, RD_DATA, SS_OFF};
    assign wait_state   = state inside {WAIT_T1, WAIT_R1, WAIT_T2, WAIT_R2};
    // One counter serves both roles: access phase (0,1 strobed, 2 idle) and wait-state dwell time.
    assign access_done  = (cnt == 16'd2);
    assign wait_expired = (cnt >= TIMEOUT - 16'd1);
    assign unused_hi    = ^data_to_cpu[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            write_q   <= 1'b0;
            reg_q     <= 5'd0;
            wdata_q   <= 8'd0;
            rx_byte   <= 8'd0;
            err_q     <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_error <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= 16'd0;
            else if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
            if (state == IDLE && cmd_valid) begin
                write_q <= cmd_write;
                reg_q   <= cmd_reg;
                wdata_q <= cmd_wdata;
                err_q   <= 1'b0;
            end
            if (state == RD_DATA && cnt == 16'd1)
                rx_byte <= data_to_cpu[7:0];
            if (wait_state && next_state == SS_OFF)
                err_q <= 1'b1;
            // Response registers change only when a new response is about to be presented.
            if (state == SS_OFF && next_state == DONE) begin
                rsp_rdata <= err_q ? 8'h00 : rx_byte;
                rsp_error <= err_q;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (cmd_valid) next_state = SS_ON;
            SS_ON:    if (access_done) next_state = WAIT_T1;
            WAIT_T1:  if (readyfordata) next_state = TX_CMD;
                      else if (wait_expired) next_state = SS_OFF;
            TX_CMD:   if (access_done) next_state = WAIT_R1;
            WAIT_R1:  if (dataavailable) next_state = RD_DUMMY;
                      else if (wait_expired) next_state = SS_OFF;
            RD_DUMMY: if (access_done) next_state = WAIT_T2;
            WAIT_T2:  if (readyfordata) next_state = TX_DATA;
                      else if (wait_expired) next_state = SS_OFF;
            TX_DATA:  if (access_done) next_state = WAIT_R2;
            WAIT_R2:  if (dataavailable) next_state = RD_DATA;
                      else if (wait_expired) next_state = SS_OFF;
            RD_DATA:  if (access_done) next_state = SS_OFF;
            SS_OFF:   if (access_done) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state == IDLE);
        rsp_valid     = (state == DONE);
        spi_select    = 1'b0;
        mem_addr      = 3'd0;
        data_from_cpu = 16'd0;
        write_n       = 1'b1;
        read_n        = 1'b1;
        if (access_state && cnt < 16'd2) begin
            spi_select = 1'b1;
            case (state)
                SS_ON: begin
                    mem_addr      = 3'd3;
                    data_from_cpu = 16'h0400;
                    write_n       = 1'b0;
                end
                TX_CMD: begin
                    mem_addr      = 3'd1;
                    data_from_cpu = {8'h00, cmd_byte};
                    write_n       = 1'b0;
                end
                TX_DATA: begin
                    mem_addr      = 3'd1;
                    data_from_cpu = {8'h00, write_q ? wdata_q : 8'h00};
                    write_n       = 1'b0;
                end
                RD_DUMMY, RD_DATA: begin
                    mem_addr = 3'd0;
                    read_n   = 1'b0;
                end
                SS_OFF: begin
                    mem_addr      = 3'd3;
                    data_from_cpu = 16'h0000;
                    write_n       = 1'b0;
                end
                default: begin
                    mem_addr = 3'd0;
                end
            endcase
        end
    end

endmodule
